// File: rtl/color_class_render.sv
// Renders the 3-bit pixel class stream into 12-bit palette RGB through a 2-entry skid buffer.
// Optional per-frame class histogram under COLOR_CLASS_RENDER_HIST_EN.
module color_class_render #(
  parameter logic [11:0] RGB_RED    = 12'hF00,
  parameter logic [11:0] RGB_ORANGE = 12'hF80,
  parameter logic [11:0] RGB_YELLOW = 12'hFF0,
  parameter logic [11:0] RGB_LOWHUE = 12'hF0F,
  parameter logic [11:0] RGB_NONE   = 12'h000
`ifdef COLOR_CLASS_RENDER_HIST_EN
  ,
  parameter int          CNT_W      = 17
`endif
) (
  input  logic             clk_in,
  input  logic             rstn_in,
  input  logic [2:0]       cls_in,
  input  logic             sof_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [11:0]      rgb_out,
  output logic             sof_out,
  output logic             valid_out,
  input  logic             ready_in
`ifdef COLOR_CLASS_RENDER_HIST_EN
  ,
  output logic [CNT_W-1:0] cnt_red_out,
  output logic [CNT_W-1:0] cnt_orange_out,
  output logic [CNT_W-1:0] cnt_yellow_out,
  output logic [CNT_W-1:0] cnt_lowhue_out,
  output logic [CNT_W-1:0] cnt_none_out,
  output logic             cnt_valid_out
`endif
);

  logic [11:0] w_rgb;
  logic        w_in_xfer;
  logic        w_out_free;

  logic        r_ready;
  logic        r_ov;
  logic [11:0] r_orgb;
  logic        r_osof;
  logic        r_sv;
  logic [11:0] r_srgb;
  logic        r_ssof;

  always_comb begin
    w_rgb = RGB_NONE;
    case (cls_in)
      3'b001:  w_rgb = RGB_RED;
      3'b100:  w_rgb = RGB_ORANGE;
      3'b010:  w_rgb = RGB_YELLOW;
      3'b011:  w_rgb = RGB_LOWHUE;
      default: w_rgb = RGB_NONE;
    endcase
  end

  // ready_out tracks skid-empty, so an accept never meets a full skid
  assign w_in_xfer  = valid_in & r_ready;
  assign w_out_free = ~r_ov | ready_in;

  always_ff @(posedge clk_in) begin
    if (!rstn_in) begin
      r_ready <= 1'b0;
      r_ov    <= 1'b0;
      r_orgb  <= 12'h000;
      r_osof  <= 1'b0;
      r_sv    <= 1'b0;
      r_srgb  <= 12'h000;
      r_ssof  <= 1'b0;
    end else begin
      if (w_out_free) begin
        if (r_sv) begin
          r_ov    <= 1'b1;
          r_orgb  <= r_srgb;
          r_osof  <= r_ssof;
          r_sv    <= 1'b0;
          r_ready <= 1'b1;
        end else if (w_in_xfer) begin
          r_ov    <= 1'b1;
          r_orgb  <= w_rgb;
          r_osof  <= sof_in;
          r_ready <= 1'b1;
        end else begin
          r_ov    <= 1'b0;
          r_ready <= 1'b1;
        end
      end else if (w_in_xfer) begin
        r_sv    <= 1'b1;
        r_srgb  <= w_rgb;
        r_ssof  <= sof_in;
        r_ready <= 1'b0;
      end else begin
        r_ready <= ~r_sv;
      end
    end
  end

  assign ready_out = r_ready;
  assign valid_out = r_ov;
  assign rgb_out   = r_orgb;
  assign sof_out   = r_osof;

`ifdef COLOR_CLASS_RENDER_HIST_EN
  // counter index: 0 red, 1 orange, 2 yellow, 3 lowhue, 4 none
  logic [2:0]       w_idx;
  logic [CNT_W-1:0] r_cnt [5];
  logic [CNT_W-1:0] r_out [5];
  logic             r_cv;
  logic             r_armed;

  always_comb begin
    w_idx = 3'd4;
    case (cls_in)
      3'b001:  w_idx = 3'd0;
      3'b100:  w_idx = 3'd1;
      3'b010:  w_idx = 3'd2;
      3'b011:  w_idx = 3'd3;
      default: w_idx = 3'd4;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rstn_in) begin
      for (int i = 0; i < 5; i++) begin
        r_cnt[i] <= '0;
        r_out[i] <= '0;
      end
      r_cv    <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_cv <= 1'b0;
      if (w_in_xfer) begin
        if (sof_in) begin
          if (r_armed) begin
            for (int i = 0; i < 5; i++) r_out[i] <= r_cnt[i];
            r_cv <= 1'b1;
          end
          r_armed <= 1'b1;
          for (int i = 0; i < 5; i++)
            r_cnt[i] <= (w_idx == 3'(i)) ? CNT_W'(1) : '0;
        end else begin
          for (int i = 0; i < 5; i++)
            if (w_idx == 3'(i) && r_cnt[i] != {CNT_W{1'b1}})
              r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign cnt_red_out    = r_out[0];
  assign cnt_orange_out = r_out[1];
  assign cnt_yellow_out = r_out[2];
  assign cnt_lowhue_out = r_out[3];
  assign cnt_none_out   = r_out[4];
  assign cnt_valid_out  = r_cv;
`endif

endmodule
